// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and registers the difference with borrow, overflow and zero flags.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             dbit;
  logic             bnext;
  logic [WIDTH-1:0] dnext;
  logic             last;

  // Difference bits enter at the MSB so the word is aligned after WIDTH shifts
  always_comb begin
    dbit  = a_sr[0] ^ b_sr[0] ^ borrow;
    bnext = (~a_sr[0] & b_sr[0])
          | (~(a_sr[0] ^ b_sr[0]) & borrow);
    dnext = {dbit, diff_sr[WIDTH-1:1]};
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      d       <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            borrow  <= bin;
            diff_sr <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          borrow  <= bnext;
          diff_sr <= dnext;
          cnt     <= cnt + 1'b1;
          if (last) begin
            // borrow here is the borrow into the MSB
            d     <= dnext;
            bout  <= bnext;
            ovf   <= borrow ^ bnext;
            zero  <= (dnext == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor against an
// arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;
  logic         zero;

  int n_cmp;
  int n_bad;

  logic [W-1:0] exp_d;
  logic         exp_bout;
  logic         exp_ovf;
  logic         exp_zero;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views
  task automatic model(input logic [W-1:0] ma,
                       input logic [W-1:0] mb,
                       input logic mbin);
    longint ua, ub, sa, sb, r, sr;
    ua = ma;
    ub = mb;
    sa = ma[W-1] ? ua - (64'sd1 <<< W) : ua;
    sb = mb[W-1] ? ub - (64'sd1 <<< W) : ub;
    r  = ua - ub - mbin;
    sr = sa - sb - mbin;
    exp_d    = W'(r);
    exp_bout = (ua < ub + mbin);
    exp_ovf  = (sr < -(64'sd1 <<< (W-1))) ||
               (sr > (64'sd1 <<< (W-1)) - 1);
    exp_zero = (exp_d == '0);
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_d"}, d, exp_d);
    chk({tag, "_bout"}, bout, exp_bout);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    chk({tag, "_zero"}, zero, exp_zero);
  endtask

  // One operation; junk=1 pulses start with other operands while busy
  task automatic run_op(input logic [W-1:0] oa,
                        input logic [W-1:0] ob,
                        input logic obin,
                        input bit junk,
                        input string tag);
    @(negedge clk);
    a = oa;
    b = ob;
    bin = obin;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      chk({tag, "_busy"}, busy, cyc <= W);
      chk({tag, "_done"}, done, cyc == W + 1);
      if (cyc == W + 1) model(oa, ob, obin);
      if (cyc == 1 || cyc == W + 1) chk_out(tag);
      start = junk ? 1'($urandom) : 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk_out({tag, "_hold"});
  endtask

  initial begin
    int t0, t1, ndone;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    exp_d = '0;
    exp_bout = 1'b0;
    exp_ovf = 1'b0;
    exp_zero = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_out("rst");
    rst = 1'b0;

    run_op(4'b0101, 4'b0011, 1'b0, 0, "v030");
    run_op(4'b0000, 4'b0001, 1'b0, 0, "v031");
    run_op(4'b1000, 4'b0001, 1'b0, 0, "v032a");
    run_op(4'b0011, 4'b0011, 1'b1, 0, "v032b");
    run_op(4'b0101, 4'b0101, 1'b0, 0, "v033");
    run_op(4'b1010, 4'b0110, 1'b1, 1, "v034");
    run_op(4'b0111, 4'b1000, 1'b0, 0, "ovf_pos");
    run_op(4'b1111, 4'b1111, 1'b1, 0, "all_ones");

    for (int i = 0; i < 24; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             1'($urandom), "rnd");

    // Reset two cycles into RUN aborts without a done pulse
    @(negedge clk);
    a = 4'b1001;
    b = 4'b0010;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_d = '0;
    exp_bout = 1'b0;
    exp_ovf = 1'b0;
    exp_zero = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk_out("abort");
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 2 * W; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk_out("abort_held");
    run_op(4'b0110, 4'b0001, 1'b1, 0, "post_rst");

    // start held high: one operation every W+2 cycles
    @(negedge clk);
    a = 4'b1100;
    b = 4'b0101;
    bin = 1'b0;
    start = 1'b1;
    t0 = -1;
    t1 = -1;
    for (int c = 0; c < 40 && t1 < 0; c++) begin
      @(negedge clk);
      if (done) begin
        if (t0 < 0) t0 = c;
        else t1 = c;
      end
    end
    start = 1'b0;
    chk("stream_seen", t1 >= 0, 1);
    chk("stream_period", t1 - t0, W + 2);
    model(4'b1100, 4'b0101, 1'b0);
    chk_out("stream");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
